// File: rtl/time_counter_if.sv
// Time-of-day counter bus: load/enable controls in, current time and pulses out.
interface time_counter_if;
    logic [23:0] setup_data;
    logic        setup_imp;
    logic        run;
    logic [23:0] data_ch;
    logic        sec_tick;
    logic        day_wrap;

    // Controller side: drives the load and enable, observes the time
    modport master (
        output setup_data,
        output setup_imp,
        output run,
        input  data_ch,
        input  sec_tick,
        input  day_wrap
    );

    // Counter side
    modport slave (
        input  setup_data,
        input  setup_imp,
        input  run,
        output data_ch,
        output sec_tick,
        output day_wrap
    );
endinterface

// File: rtl/time_counter.sv
// Hours/minutes/seconds counter driven by a CLK_HZ prescaler, with a
// level-sensitive load that clamps out-of-range fields to zero.
module time_counter #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic         clock,
    input  logic         reset,
    time_counter_if.slave bus
);

    localparam int unsigned PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;
    localparam int unsigned HR_W  = 5;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(59);
    localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(23);

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } hms_t;

    logic [PS_W-1:0] ps_q, ps_d;
    hms_t            time_q, time_d;
    logic            sec_tick_q, sec_tick_d;
    logic            day_wrap_q, day_wrap_d;

    hms_t            load_c;
    hms_t            adv_c;
    logic            wrap_c;
    logic            ps_last_c;

    // Clamp each incoming field independently; anything out of range loads as zero
    always_comb begin
        load_c     = '0;
        load_c.sec = (bus.setup_data[7:0]   > 8'd59) ? '0 : SEC_W'(bus.setup_data[7:0]);
        load_c.min = (bus.setup_data[15:8]  > 8'd59) ? '0 : MIN_W'(bus.setup_data[15:8]);
        load_c.hr  = (bus.setup_data[23:16] > 8'd23) ? '0 : HR_W'(bus.setup_data[23:16]);
    end

    // One-second advance of the current time with cascaded carries
    always_comb begin
        adv_c  = time_q;
        wrap_c = 1'b0;
        if (time_q.sec == SEC_LAST) begin
            adv_c.sec = '0;
            if (time_q.min == MIN_LAST) begin
                adv_c.min = '0;
                if (time_q.hr == HR_LAST) begin
                    adv_c.hr = '0;
                    wrap_c   = 1'b1;
                end else begin
                    adv_c.hr = time_q.hr + HR_W'(1);
                end
            end else begin
                adv_c.min = time_q.min + MIN_W'(1);
            end
        end else begin
            adv_c.sec = time_q.sec + SEC_W'(1);
        end
    end

    assign ps_last_c = (ps_q == PS_LAST);

    // Next-state: load beats a coincident terminal count; run=0 freezes everything
    always_comb begin
        ps_d       = ps_q;
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        if (bus.setup_imp) begin
            ps_d   = '0;
            time_d = load_c;
        end else if (bus.run) begin
            if (ps_last_c) begin
                ps_d       = '0;
                time_d     = adv_c;
                sec_tick_d = 1'b1;
                day_wrap_d = wrap_c;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // State and output registers; reset drops any partial second
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ps_q       <= '0;
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    // Pack registered fields into the byte-aligned output layout, spare bits zero
    assign bus.data_ch  = {3'b000, time_q.hr, 2'b00, time_q.min, 2'b00, time_q.sec};
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_wrap = day_wrap_q;

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per second (prescaler terminal count + 1); must be >= 2.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port setup_data  input  24  time to load: [7:0] seconds, [15:8] minutes, [23:16] hours, plain binary.
REQ-005 SHALL have port setup_imp  input  1  load request, level-sensitive, may stay high for many cycles.
REQ-006 SHALL have port run  input  1  count enable; 0 freezes prescaler and time.
REQ-007 SHALL have port data_ch  output  24  current time, same field layout as setup_data.
REQ-008 SHALL have port sec_tick  output  1  one-cycle pulse coincident with each one-second advance of data_ch.
REQ-009 SHALL have port day_wrap  output  1  one-cycle pulse coincident with the 23:59:59 -> 00:00:00 advance.

Function
REQ-010 SHALL keep an internal prescaler counting 0..CLK_HZ-1, incrementing by 1 each cycle while run=1 and setup_imp=0.
REQ-011 SHALL, on the edge where prescaler = CLK_HZ-1 and run=1 and setup_imp=0, set prescaler to 0, advance data_ch by one second, and assert sec_tick for exactly that following cycle.
REQ-012 SHALL advance time as: seconds+1; if seconds was 59 -> seconds 0, minutes+1; if minutes was 59 -> minutes 0, hours+1; if hours was 23 -> hours 0.
REQ-013 SHALL assert day_wrap only on the advance from 23:59:59 to 00:00:00, in the same cycle as sec_tick.
REQ-014 SHALL keep data_ch[7:6], [15:14], [23:21] always 0; every field in range (sec/min 0..59, hr 0..23).
REQ-015 SHALL, in every cycle setup_imp=1, load data_ch from setup_data, clear prescaler to 0, and drive sec_tick=0, day_wrap=0, regardless of run.
REQ-016 SHALL load any out-of-range field (sec>59, min>59, hr>23) as 0, other fields loaded unchanged.
REQ-017 SHALL give setup_imp priority over a coincident prescaler terminal count: load wins, no advance that cycle.
REQ-018 SHALL, while run=0 and setup_imp=0, hold prescaler and data_ch; sec_tick and day_wrap 0.
REQ-019 SHALL resume counting after setup_imp falls from prescaler 0, so first advance occurs exactly CLK_HZ cycles (with run=1) after the last load cycle.
REQ-020 SHALL register all outputs (no combinational path from inputs to outputs); load visible on data_ch one cycle after setup_imp sampled high.
REQ-021 SHALL size prescaler as ceil(log2(CLK_HZ)) bits; no other wrap behaviour permitted.

Reset
REQ-022 SHALL, while reset=0, asynchronously force data_ch=0, prescaler=0, sec_tick=0, day_wrap=0.
REQ-023 SHALL, after reset deassertion, count the first second as a full CLK_HZ cycles (with run=1).
REQ-024 SHALL discard any partial second when reset asserts mid-count; no tick emitted on release.

Verification (CLK_HZ=4)
REQ-025 SHALL cover: reset, run=1 for 12 cycles -> sec_tick on cycles 4, 8, 12; data_ch 00:00:03 (0x000003).
REQ-026 SHALL cover: setup_imp=1 one cycle with setup_data=0x173B3B (23:59:59), then run=1 -> 4 cycles later data_ch=0x000000, sec_tick=1 and day_wrap=1 in same cycle.
REQ-027 SHALL cover: load 0x0A3B3B (10:59:59), one tick -> data_ch=0x0B0000, day_wrap=0.
REQ-028 SHALL cover: setup_imp held 10 cycles with setup_data=0x050A14 while run=1 -> data_ch=0x050A14 throughout, no sec_tick; first tick 4 cycles after setup_imp falls -> 0x050A15.
REQ-029 SHALL cover: setup_data=0x183C3C (24:60:60) loaded -> data_ch=0x000000; setup_data=0x0C3C05 -> 0x0C0005.
REQ-030 SHALL cover: run=0 for 7 cycles after prescaler=2, then run=1 -> tick exactly 2 run-cycles later; reset pulse at prescaler=3 -> data_ch=0, no tick on release.
